mac_accum_stage: RTL

//  Downstream stage of the 16-bit sign-magnitude multiply unit: consumes product words
//  (bit15 sign, bits14:0 magnitude, bits31:16 zero) plus the multiplier's carry-out and

---
 rtl/mac_pkg.sv | 13 +
 rtl/mac_accum_stage_sm_to_tc.sv | 23 ++
 rtl/mac_accum_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared types and sign-magnitude field constants for the MAC accumulate stage.
package mac_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        OUT   = 1'b1
    } state_t;

    localparam int             SIGN_BIT = 15;
    localparam int             MAG_W    = 15;
    localparam logic [MAG_W-1:0] MAG_MAX = 15'h7FFF;

endpackage

// File: rtl/mac_accum_stage_sm_to_tc.sv
// Converts a 16-bit sign-magnitude product (plus multiplier carry-out) into a
// sign-extended two's-complement accumulator operand.
module sm_to_tc
    import mac_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [MAG_W:0]          sm_i,
    input  logic                    cout_i,
    output logic signed [ACC_W-1:0] val_o,
    output logic                    ovf_o
);

    logic [MAG_W-1:0]        mag;
    logic signed [ACC_W-1:0] mag_ext;

    // A carry-out means the true magnitude did not fit, so pin it to full scale.
    assign mag     = cout_i ? MAG_MAX : sm_i[MAG_W-1:0];
    assign mag_ext = {{(ACC_W-MAG_W){1'b0}}, mag};
    assign val_o   = sm_i[SIGN_BIT] ? -mag_ext : mag_ext;
    assign ovf_o   = cout_i;

endmodule

// File: rtl/mac_accum_stage.sv
// Accumulates sign-magnitude products into a saturating signed accumulator and
// returns one sign-magnitude dot-product per burst over a valid/ready port.
module mac_accum_stage
    import mac_pkg::*;
#(
    parameter int N         = 32,
    parameter int ACC_W     = 24,
    parameter int MAX_BEATS = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N-1:0]                   in_prod,
    input  logic                           in_cout,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N-1:0]                   out_res,
    output logic                           out_zero,
    output logic                           out_neg,
    output logic                           out_ovf,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_beats
);

    localparam int CNT_W = $clog2(MAX_BEATS+1);
    localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};

    function automatic logic sat_hit(input logic signed [ACC_W:0] s);
        return (s > ACC_MAX) || (s < -ACC_MAX);
    endfunction

    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W:0] s);
        logic signed [ACC_W:0] r;
        if (s > ACC_MAX)
            r = ACC_MAX;
        else if (s < -ACC_MAX)
            r = -ACC_MAX;
        else
            r = s;
        return r[ACC_W-1:0];
    endfunction

    // Returns {overflow, sign, magnitude}; a zero magnitude always carries a + sign.
    function automatic logic [MAG_W+1:0] to_sm(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] abs_v;
        logic [MAG_W-1:0] mag;
        logic             over;
        abs_v = a[ACC_W-1] ? -a : a;
        over  = abs_v > {{(ACC_W-MAG_W){1'b0}}, MAG_MAX};
        mag   = over ? MAG_MAX : abs_v[MAG_W-1:0];
        return {over, a[ACC_W-1] && (mag != '0), mag};
    endfunction

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ovf_q, ovf_d;
    logic [MAG_W:0]          res_q, res_d;
    logic                    zero_q, zero_d;
    logic                    rovf_q, rovf_d;
    logic [CNT_W-1:0]        beats_q, beats_d;

    logic signed [ACC_W-1:0] val;
    logic                    val_ovf;
    logic signed [ACC_W:0]   acc_x, val_x, sum;
    logic signed [ACC_W-1:0] acc_nxt;
    logic                    ovf_nxt;
    logic [MAG_W+1:0]        conv;
    logic                    unused_hi;

    sm_to_tc #(.ACC_W(ACC_W)) u_sm_to_tc (
        .sm_i   (in_prod[SIGN_BIT:0]),
        .cout_i (in_cout),
        .val_o  (val),
        .ovf_o  (val_ovf)
    );

    assign unused_hi = ^in_prod[N-1:SIGN_BIT+1];

    assign acc_x   = {acc_q[ACC_W-1], acc_q};
    assign val_x   = {val[ACC_W-1], val};
    assign sum     = acc_x + val_x;
    assign acc_nxt = sat(sum);
    assign ovf_nxt = ovf_q | val_ovf | sat_hit(sum);
    assign conv    = to_sm(acc_nxt);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        res_d    = res_q;
        zero_d   = zero_q;
        rovf_d   = rovf_q;
        beats_d  = beats_q;
        in_ready = 1'b0;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            res_d   = '0;
            zero_d  = 1'b0;
            rovf_d  = 1'b0;
            beats_d = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        acc_d = acc_nxt;
                        cnt_d = cnt_q + CNT_W'(1);
                        ovf_d = ovf_nxt;
                        if (in_last || (cnt_q == CNT_W'(MAX_BEATS-1))) begin
                            res_d   = conv[MAG_W:0];
                            zero_d  = (conv[MAG_W-1:0] == '0);
                            rovf_d  = ovf_nxt | conv[MAG_W+1];
                            beats_d = cnt_q + CNT_W'(1);
                            state_d = OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            rovf_q  <= 1'b0;
            beats_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            rovf_q  <= rovf_d;
            beats_q <= beats_d;
        end
    end

    assign out_valid = (state_q == OUT);
    assign out_res   = {{(N-MAG_W-1){1'b0}}, res_q};
    assign out_zero  = zero_q;
    assign out_neg   = res_q[SIGN_BIT];
    assign out_ovf   = rovf_q;
    assign out_beats = beats_q;

endmodule
